count_memory_reader: RTL

- Read-side companion of the photon-count sample memory (1024 x 16-bit, one word written per DMD pattern).
- On a start request, walks addresses 0..N-1 and reads each stored count through a synchronous read port with 1-cycle latency.
- Serialises each word MSB-byte first onto a valid/ready byte stream that feeds the host UART transmitter.
- Sits between the sample memory and the UART TX in the FPGA-only controller.

---
 rtl/pc_ctrl_pkg.sv | 26 ++
 rtl/count_memory_reader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the photon-count controller: memory geometry, reader FSM
// encoding and the byte order used on the host link.
package pc_ctrl_pkg;

    localparam int PC_ADDR_W = 10;
    localparam int PC_DATA_W = 16;
    localparam int PC_DEPTH  = 1024;

    // Words travel MSB byte first; the memory writer and host scripts rely on this too.
    localparam bit PC_MSB_FIRST = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FETCH   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_SEND_HI = 3'd3;
    localparam state_t ST_SEND_LO = 3'd4;
    localparam state_t ST_FINISH  = 3'd5;
    localparam state_t ST_CHK     = 3'd6;

    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic first);
        return (first == PC_MSB_FIRST) ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/count_memory_reader.sv
// Reads N photon-count words from the sample memory and streams them as bytes to the
// UART TX. Define COUNT_READER_CHECKSUM_EN to append a modulo-256 byte-sum trailer.
module count_memory_reader
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
    parameter int DATA_W = PC_DATA_W,
    parameter int DEPTH  = PC_DEPTH
) (
    input  logic              clk,
    input  logic              RD,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                zdone_q, zdone_d;
    logic                last_word;
`ifdef COUNT_READER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    assign last_word = ({1'b0, addr_q} == (len_q - 1'b1));

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_SEND_HI: tx_data = word_byte(word_q, 1'b1);
            ST_SEND_LO: tx_data = word_byte(word_q, 1'b0);
`ifdef COUNT_READER_CHECKSUM_EN
            ST_CHK:     tx_data = sum_q;
`endif
            default:    tx_data = 8'h00;
        endcase
    end

    assign tx_valid  = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO)
`ifdef COUNT_READER_CHECKSUM_EN
                    || (state_q == ST_CHK)
`endif
                    ;
    assign mem_rd_en = (state_q == ST_FETCH);
    assign mem_addr  = addr_q;
    assign busy      = (state_q != ST_IDLE);
    // A zero-length request completes straight from IDLE, so busy never rises.
    assign done      = (state_q == ST_FINISH) || zdone_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        word_d  = word_q;
        zdone_d = 1'b0;
`ifdef COUNT_READER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef COUNT_READER_CHECKSUM_EN
                    sum_d = 8'h00;
`endif
                    if (count == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        len_d   = (count > DEPTH_L) ? DEPTH_L : count;
                        addr_d  = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                word_d  = mem_data;
                state_d = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (tx_ready) begin
`ifdef COUNT_READER_CHECKSUM_EN
                    sum_d = sum_q + tx_data;
`endif
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (tx_ready) begin
`ifdef COUNT_READER_CHECKSUM_EN
                    sum_d = sum_q + tx_data;
`endif
                    if (last_word) begin
`ifdef COUNT_READER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_FINISH;
`endif
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef COUNT_READER_CHECKSUM_EN
            ST_CHK: begin
                if (tx_ready) state_d = ST_FINISH;
            end
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RD) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            zdone_q <= zdone_d;
        end
    end

    // Datapath registers are only observed in states entered after they are loaded.
    always_ff @(posedge clk) begin
        word_q <= word_d;
`ifdef COUNT_READER_CHECKSUM_EN
        sum_q  <= sum_d;
`endif
    end

endmodule
